// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared state type and default sizing for the register dump engine.
package reg_dump_pkg;
  localparam int NUM_REGS_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int IDX_W = 3;
  typedef enum logic [1:0] {IDLE, SETUP, PRESENT, DONE} state_e;
endpackage

// File: rtl/reg_dump.sv
// reg_dump: walks a register file's read port and presents each word on a valid/ready stream.
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [IDX_W-1:0]  sr_sel_o,
  input  logic [DATA_W-1:0] sr_data_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [IDX_W-1:0]  out_idx_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              done_o
);
  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, out_idx_q, out_idx_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic last;
  assign last = idx_q == IDX_W'(NUM_REGS - 1);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      out_idx_q  <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_idx_q  <= out_idx_d;
      out_data_q <= out_data_d;
    end
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    out_idx_d  = out_idx_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        state_d = start_i ? SETUP : IDLE;
        idx_d   = '0;
      end
      SETUP: begin
        state_d    = PRESENT;
        out_data_d = sr_data_i;
        out_idx_d  = idx_q;
      end
      PRESENT: begin
        state_d = !out_ready_i ? PRESENT : last ? DONE : SETUP;
        idx_d   = (out_ready_i && !last) ? idx_q + IDX_W'(1) : idx_q;
      end
      default: begin
        // leave idx at 0 so the read-select idles at register 0
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end
  assign sr_sel_o    = idx_q;
  assign out_data_o  = out_data_q;
  assign out_idx_o   = out_idx_q;
  assign out_valid_o = state_q == PRESENT;
  assign busy_o      = state_q == SETUP || state_q == PRESENT;
  assign done_o      = state_q == DONE;
endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: reg_dump paired with a behavioural register file, checked against scenario-level expectations.
module tb_reg_dump;
  logic clk = 0, rst = 1, start = 0, ready = 0;
  logic [2:0] sr_sel, out_idx;
  logic [15:0] sr_data, out_data;
  logic out_valid, busy, done;
  logic [15:0] rf [8];
  int tot = 0, bad = 0;
  int got_idx [$];
  logic [15:0] got_data [$];
  int done_cnt, done_cyc, first_v, end_cyc, stall_tot;
  bit timed_out, aborted;
  logic tr_valid [400];
  logic [2:0] tr_idx [400];
  logic [15:0] tr_data [400];
  int w_word [2], w_reg [2];
  logic [15:0] w_val [2];
  logic [15:0] s_data;
  logic [2:0] s_idx, s_sel;
  logic s_valid, s_busy, s_done;
  assign sr_data = rf[sr_sel];
  always #5 clk = ~clk;
  reg_dump dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sr_sel_o(sr_sel), .sr_data_i(sr_data),
    .out_data_o(out_data), .out_idx_o(out_idx), .out_valid_o(out_valid),
    .out_ready_i(ready), .busy_o(busy), .done_o(done)
  );
  task automatic preload();
    for (int i = 0; i < 8; i++) rf[i] = 16'h1000 + 16'(i);
    w_word[0] = -1;
    w_word[1] = -1;
  endtask
  // Called at a negedge; c counts negedges after the edge that samples start.
  task automatic collect(input int stall_idx, input int stall_len, input bit rnd, input bit restart, input int abort_idx);
    int stall_cnt = 0;
    bit seen_done = 0;
    bit w_done [2] = '{0, 0};
    got_idx.delete();
    got_data.delete();
    done_cnt = 0; done_cyc = -1; first_v = -1; end_cyc = -1; stall_tot = 0;
    timed_out = 1; aborted = 0;
    start = 1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      tr_valid[c] = out_valid; tr_idx[c] = out_idx; tr_data[c] = out_data;
      if (done) begin done_cnt++; done_cyc = c; seen_done = 1; end
      if (out_valid && first_v < 0) first_v = c;
      if (abort_idx >= 0 && out_valid && out_idx == 3'(abort_idx)) begin
        rst = 1;
        #1;
        s_data = out_data; s_idx = out_idx; s_sel = sr_sel;
        s_valid = out_valid; s_busy = busy; s_done = done;
        aborted = 1; timed_out = 0; start = 0;
        break;
      end
      for (int i = 0; i < 2; i++)
        if (!w_done[i] && out_valid && w_word[i] == int'(out_idx)) begin
          rf[w_reg[i]] = w_val[i];
          w_done[i] = 1;
        end
      if (stall_idx >= 0 && out_valid && out_idx == 3'(stall_idx) && stall_cnt < stall_len) begin
        ready = 0;
        stall_cnt++;
      end else ready = rnd ? 1'($urandom % 2) : 1'b1;
      if (out_valid && !ready) stall_tot++;
      if (out_valid && ready) begin got_idx.push_back(int'(out_idx)); got_data.push_back(out_data); end
      start = restart && busy && 1'($urandom % 2);
      if (seen_done && !busy && !done) begin end_cyc = c; timed_out = 0; break; end
    end
    start = 0;
  endtask
  task automatic check_words(input string tag, input logic [15:0] exp [8]);
    tot++;
    if (got_idx.size() !== 8) begin bad++; $display("FAIL %s word_count got=%0d want=8", tag, got_idx.size()); end
    for (int k = 0; k < 8 && k < got_idx.size(); k++) begin
      tot++;
      if (got_idx[k] !== k || got_data[k] !== exp[k]) begin
        bad++;
        $display("FAIL %s word%0d got idx=%0d data=%h want idx=%0d data=%h", tag, k, got_idx[k], got_data[k], k, exp[k]);
      end
    end
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    tot++;
    if ({sr_sel, out_data, out_idx, out_valid, busy, done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got sel=%0d data=%h idx=%0d v=%b busy=%b done=%b want all 0", sr_sel, out_data, out_idx, out_valid, busy, done);
    end
  endtask
  task automatic test_full_dump();
    logic [15:0] exp [8];
    preload();
    for (int k = 0; k < 8; k++) exp[k] = 16'h1000 + 16'(k);
    @(negedge clk);
    rst = 0;
    collect(-1, 0, 0, 0, -1);
    tot++; if (timed_out !== 0) begin bad++; $display("FAIL full_timeout got=%b want=0", timed_out); end
    check_words("full", exp);
    tot++; if (first_v !== 1) begin bad++; $display("FAIL full_first_valid got=%0d want=1", first_v); end
    tot++; if (done_cnt !== 1 || done_cyc !== 16) begin bad++; $display("FAIL full_done got cnt=%0d cyc=%0d want cnt=1 cyc=16", done_cnt, done_cyc); end
    tot++; if (end_cyc !== 17) begin bad++; $display("FAIL full_idle_cycle got=%0d want=17", end_cyc); end
    tot++; if (sr_sel !== 3'd0) begin bad++; $display("FAIL idle_sel got=%0d want=0", sr_sel); end
  endtask
  task automatic test_stall();
    int n = 0, first = -1;
    preload();
    collect(3, 5, 0, 0, -1);
    tot++; if (timed_out !== 0) begin bad++; $display("FAIL stall_timeout got=%b want=0", timed_out); end
    for (int c = 0; c <= end_cyc; c++)
      if (tr_valid[c] && tr_idx[c] == 3'd3) begin
        if (first < 0) first = c;
        n++;
        tot++;
        if (tr_data[c] !== 16'h1003) begin bad++; $display("FAIL stall_data c=%0d got=%h want=1003", c, tr_data[c]); end
      end
    tot++; if (n !== 6) begin bad++; $display("FAIL stall_hold_cycles got=%0d want=6", n); end
    for (int c = first; c >= 0 && c < first + 6; c++) begin
      tot++;
      if (tr_valid[c] !== 1'b1 || tr_idx[c] !== 3'd3) begin bad++; $display("FAIL stall_valid c=%0d got v=%b idx=%0d want v=1 idx=3", c, tr_valid[c], tr_idx[c]); end
    end
    tot++; if (end_cyc !== 22) begin bad++; $display("FAIL stall_idle_cycle got=%0d want=22", end_cyc); end
  endtask
  task automatic test_writes();
    logic [15:0] exp [8];
    preload();
    for (int k = 0; k < 8; k++) exp[k] = 16'h1000 + 16'(k);
    exp[5] = 16'hBEEF;
    w_word[0] = 2; w_reg[0] = 5; w_val[0] = 16'hBEEF;
    w_word[1] = 1; w_reg[1] = 1; w_val[1] = 16'h0000;
    collect(-1, 0, 0, 0, -1);
    tot++; if (timed_out !== 0) begin bad++; $display("FAIL writes_timeout got=%b want=0", timed_out); end
    check_words("writes", exp);
  endtask
  task automatic test_back_to_back();
    logic [15:0] exp [8];
    preload();
    for (int k = 0; k < 8; k++) exp[k] = 16'h1000 + 16'(k);
    collect(-1, 0, 0, 1, -1);
    tot++; if (timed_out !== 0) begin bad++; $display("FAIL restart_timeout got=%b want=0", timed_out); end
    check_words("restart", exp);
    tot++; if (done_cnt !== 1 || end_cyc !== 17) begin bad++; $display("FAIL restart_done got cnt=%0d end=%0d want cnt=1 end=17", done_cnt, end_cyc); end
    repeat (3) @(negedge clk);
    tot++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL restart_queued got busy=%b done=%b want 0 0", busy, done); end
  endtask
  task automatic test_random();
    logic [15:0] exp [8];
    for (int it = 0; it < 4; it++) begin
      preload();
      for (int k = 0; k < 8; k++) begin rf[k] = 16'($urandom); exp[k] = rf[k]; end
      collect(-1, 0, 1, 0, -1);
      tot++; if (timed_out !== 0) begin bad++; $display("FAIL rand%0d_timeout got=%b want=0", it, timed_out); end
      check_words("random", exp);
      tot++; if (done_cnt !== 1 || end_cyc !== 17 + stall_tot) begin bad++; $display("FAIL rand%0d_timing got cnt=%0d end=%0d want cnt=1 end=%0d", it, done_cnt, end_cyc, 17 + stall_tot); end
    end
  endtask
  task automatic test_abort();
    logic [15:0] exp [8];
    preload();
    for (int k = 0; k < 8; k++) exp[k] = 16'h1000 + 16'(k);
    collect(-1, 0, 0, 0, 4);
    tot++; if (aborted !== 1'b1) begin bad++; $display("FAIL abort_reached got=%b want=1", aborted); end
    tot++;
    if ({s_sel, s_data, s_idx, s_valid, s_busy, s_done} !== '0) begin
      bad++;
      $display("FAIL abort_outputs got sel=%0d data=%h idx=%0d v=%b busy=%b done=%b want all 0", s_sel, s_data, s_idx, s_valid, s_busy, s_done);
    end
    tot++; if (done_cnt !== 0) begin bad++; $display("FAIL abort_done_before got=%0d want=0", done_cnt); end
    @(posedge clk);
    #1;
    tot++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_done_after got done=%b busy=%b want 0 0", done, busy); end
    @(negedge clk);
    rst = 0;
    collect(-1, 0, 0, 0, -1);
    tot++; if (timed_out !== 0) begin bad++; $display("FAIL abort_restart_timeout got=%b want=0", timed_out); end
    check_words("after_abort", exp);
  endtask
  initial begin
    test_reset();
    test_full_dump();
    test_stall();
    test_writes();
    test_back_to_back();
    test_random();
    test_abort();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
